// File: rtl/shift_unit_arbiter_if.sv
// ============================================================================
// Module   : shift_unit_arbiter_if
// Brief    : Request/response bundle for the shared two-port shift unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_unit_arbiter_if;
    logic        i_req0_valid;
    logic        o_req0_ready;
    logic [1:0]  i_req0_op;
    logic [31:0] i_req0_a;
    logic [4:0]  i_req0_b;

    logic        i_req1_valid;
    logic        o_req1_ready;
    logic [1:0]  i_req1_op;
    logic [31:0] i_req1_a;
    logic [4:0]  i_req1_b;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_id;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
    );

    modport master (
        output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/shift_unit_arbiter.sv
// ============================================================================
// Module   : shift_unit_arbiter
// Brief    : Round-robin shared 32-bit shifter with a single registered result slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_arbiter (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    shift_unit_arbiter_if.slave   bus
);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b11;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic        r_ptr;
    logic        w_grant;
    logic        w_any_valid;
    logic        w_can_accept;
    logic        w_req_hs;
    logic        w_rsp_hs;

    logic [1:0]  w_op;
    logic [31:0] w_a;
    logic [4:0]  w_b;
    logic [31:0] w_result;
    logic        w_err;

    logic        r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    // Prefer the port named by the pointer, fall back to the other one.
    always_comb begin
        w_any_valid = bus.i_req0_valid | bus.i_req1_valid;
        if (r_ptr == 1'b0) begin
            w_grant = bus.i_req0_valid ? 1'b0 : 1'b1;
        end else begin
            w_grant = bus.i_req1_valid ? 1'b1 : 1'b0;
        end
    end

    // Reset gating keeps both readies low while the block is held in reset.
    assign w_can_accept = (r_state == c_st_empty) | bus.i_rsp_ready;
    assign w_req_hs     = w_can_accept & w_any_valid & i_rst_n;
    assign w_rsp_hs     = (r_state == c_st_full) & bus.i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_req_hs) begin
                    w_next_state = c_st_full;
                end
            end
            c_st_full: begin
                if (w_rsp_hs && !w_req_hs) begin
                    w_next_state = c_st_empty;
                end
            end
            default: w_next_state = c_st_empty;
        endcase
    end

    always_comb begin
        bus.o_req0_ready = w_req_hs & ~w_grant;
        bus.o_req1_ready = w_req_hs &  w_grant;
        bus.o_rsp_valid  = (r_state == c_st_full);
        bus.o_rsp_id     = r_rsp_id;
        bus.o_rsp_data   = r_rsp_data;
        bus.o_rsp_err    = r_rsp_err;
    end

    assign w_op = w_grant ? bus.i_req1_op : bus.i_req0_op;
    assign w_a  = w_grant ? bus.i_req1_a  : bus.i_req0_a;
    assign w_b  = w_grant ? bus.i_req1_b  : bus.i_req0_b;

    always_comb begin
        w_result = 32'd0;
        w_err    = 1'b0;
        case (w_op)
            c_op_sll: w_result = w_a << w_b;
            c_op_srl: w_result = w_a >> w_b;
            c_op_sra: w_result = $unsigned($signed(w_a) >>> w_b);
            default:  w_err    = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else if (w_req_hs) begin
            r_ptr      <= ~w_grant;
            r_rsp_id   <= w_grant;
            r_rsp_data <= w_result;
            r_rsp_err  <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
// ============================================================================
// Module   : tb_shift_unit_arbiter
// Brief    : Self-checking bench: directed vectors, corner sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_unit_arbiter_if bus ();

    shift_unit_arbiter u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: slot contents and round-robin preference.
    logic        m_full;
    logic        m_id;
    logic [31:0] m_data;
    logic        m_err;
    logic        m_ptr;
    logic        last_hs;
    logic        last_g;

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift semantics expressed as arithmetic on powers of two.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] b, output logic err);
        longint unsigned p;
        longint unsigned prod;
        logic [31:0]     na;
        p = 1;
        for (int i = 0; i < int'(b); i++) p = p * 2;
        err = 1'b0;
        case (op)
            2'b00: begin prod = longint'(a) * p; ref_shift = prod[31:0]; end
            2'b01: ref_shift = 32'(longint'(a) / p);
            2'b11: begin
                if (a[31]) begin
                    na = ~a;
                    ref_shift = ~32'(longint'(na) / p);
                end else begin
                    ref_shift = 32'(longint'(a) / p);
                end
            end
            default: begin ref_shift = 32'd0; err = 1'b1; end
        endcase
    endfunction

    task automatic drive(input int p, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [4:0] b);
        if (p == 0) begin
            bus.i_req0_valid = v; bus.i_req0_op = op; bus.i_req0_a = a; bus.i_req0_b = b;
        end else begin
            bus.i_req1_valid = v; bus.i_req1_op = op; bus.i_req1_a = a; bus.i_req1_b = b;
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_id = 1'b0; m_data = 32'd0; m_err = 1'b0; m_ptr = 1'b0;
        last_hs = 1'b0; last_g = 1'b0;
    endtask

    // Inputs are already driven (after a negedge); check readies, clock, check slot.
    task automatic cycle();
        logic        v[2];
        logic        can;
        logic        any;
        logic        g;
        logic        hs;
        logic        rdy;
        logic [31:0] rd;
        logic        re;
        #1;
        v[0] = bus.i_req0_valid;
        v[1] = bus.i_req1_valid;
        rdy  = bus.i_rsp_ready;
        can  = !m_full || rdy;
        any  = v[0] || v[1];
        g    = v[m_ptr] ? m_ptr : !m_ptr;
        hs   = can && any;
        chk("ready0", {31'd0, bus.o_req0_ready}, {31'd0, hs && (g == 1'b0)});
        chk("ready1", {31'd0, bus.o_req1_ready}, {31'd0, hs && (g == 1'b1)});
        if (g == 1'b0) rd = ref_shift(bus.i_req0_op, bus.i_req0_a, bus.i_req0_b, re);
        else           rd = ref_shift(bus.i_req1_op, bus.i_req1_a, bus.i_req1_b, re);
        @(posedge clk);
        if (hs) begin
            m_full = 1'b1; m_id = g; m_data = rd; m_err = re; m_ptr = !g;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        last_hs = hs;
        last_g  = g;
        #1;
        chk("rsp_valid", {31'd0, bus.o_rsp_valid}, {31'd0, m_full});
        chk("rsp_id",    {31'd0, bus.o_rsp_id},    {31'd0, m_id});
        chk("rsp_data",  bus.o_rsp_data,           m_data);
        chk("rsp_err",   {31'd0, bus.o_rsp_err},   {31'd0, m_err});
    endtask

    logic        pv[2];
    logic [1:0]  pop[2];
    logic [31:0] pa[2];
    logic [4:0]  pb[2];
    logic [31:0] saved;
    logic        prev_id;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 2'b00, 32'd0, 5'd0);
        drive(1, 1'b0, 2'b00, 32'd0, 5'd0);
        bus.i_rsp_ready = 1'b0;
        model_reset();

        vecs[0] = '{1'b0, 2'b11, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        vecs[1] = '{1'b1, 2'b00, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
        vecs[3] = '{1'b1, 2'b11, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0};
        vecs[4] = '{1'b1, 2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{1'b1, 2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b1, 2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        vecs[7] = '{1'b1, 2'b11, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        vecs[8] = '{1'b0, 2'b01, 32'hF0F0F0F0, 5'd8,  32'h00F0F0F0, 1'b0};
        vecs[9] = '{1'b0, 2'b10, 32'h12345678, 5'd3,  32'h00000000, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("reset_data",  bus.o_rsp_data,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one request at a time with the consumer ready.
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].port, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            cycle();
            chk("vec_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
            chk("vec_id",    {31'd0, bus.o_rsp_id},    {31'd0, vecs[i].port});
            chk("vec_data",  bus.o_rsp_data,           vecs[i].exp_data);
            chk("vec_err",   {31'd0, bus.o_rsp_err},   {31'd0, vecs[i].exp_err});
            @(negedge clk);
            drive(vecs[i].port, 1'b0, 2'b00, 32'd0, 5'd0);
            cycle();
        end

        // Reserved op from port 0 must still advance the pointer.
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 32'h12345678, 5'd0);
        cycle();
        @(negedge clk);
        drive(1, 1'b1, 2'b00, 32'h0000000F, 5'd4);
        cycle();
        chk("ptr_after_rsvd", {31'd0, bus.o_rsp_id}, 32'd1);
        chk("ptr_after_rsvd_data", bus.o_rsp_data, 32'h000000F0);

        // Fairness: both ports continuously valid, strict alternation.
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 32'h00000003, 5'd1);
        drive(1, 1'b1, 2'b01, 32'h00000030, 5'd1);
        cycle();
        prev_id = bus.o_rsp_id;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cycle();
            chk("fair_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
            chk("fair_id",    {31'd0, bus.o_rsp_id},    {31'd0, !prev_id});
            prev_id = bus.o_rsp_id;
        end

        // Backpressure: slot full, consumer stalled three cycles, then drain+refill.
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        saved = bus.o_rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, bus.o_req1_ready}, 32'd0);
            chk("bp_data",   bus.o_rsp_data,            saved);
            @(negedge clk);
        end
        bus.i_rsp_ready = 1'b1;
        drive(0, 1'b1, 2'b00, 32'h0000AAAA, 5'd16);
        drive(1, 1'b1, 2'b00, 32'h0000BBBB, 5'd16);
        cycle();
        chk("bp_refill_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
        chk("bp_refill_data",  bus.o_rsp_data, bus.o_rsp_id ? 32'hBBBB0000 : 32'hAAAA0000);

        // Reset with a result pending from port 1; asserted mid-cycle.
        @(negedge clk);
        drive(0, 1'b0, 2'b00, 32'd0, 5'd0);
        drive(1, 1'b1, 2'b00, 32'hFFFFFFFF, 5'd1);
        bus.i_rsp_ready = 1'b0;
        cycle();
        @(negedge clk);
        drive(1, 1'b0, 2'b00, 32'd0, 5'd0);
        cycle();
        chk("pre_rst_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        drive(0, 1'b1, 2'b01, 32'h00000100, 5'd4);
        drive(1, 1'b1, 2'b01, 32'h00000200, 5'd4);
        bus.i_rsp_ready = 1'b1;
        #1;
        model_reset();
        chk("rst_valid",  {31'd0, bus.o_rsp_valid},  32'd0);
        chk("rst_id",     {31'd0, bus.o_rsp_id},     32'd0);
        chk("rst_data",   bus.o_rsp_data,            32'd0);
        chk("rst_err",    {31'd0, bus.o_rsp_err},    32'd0);
        chk("rst_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.o_req1_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_id",   {31'd0, bus.o_rsp_id}, 32'd0);
        chk("post_rst_data", bus.o_rsp_data,        32'h00000010);

        // Randomized traffic against the model, obeying the requester rules.
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pop[p] = 2'b00; pa[p] = 32'd0; pb[p] = 5'd0;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (last_hs && (last_g == p[0])) pv[p] = 1'b0;
                if (pv[p]) begin
                    if ($urandom_range(0, 9) == 0) pv[p] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    pv[p]  = 1'b1;
                    pop[p] = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0:       pa[p] = 32'h80000000;
                        1:       pa[p] = 32'h7FFFFFFF;
                        default: pa[p] = $urandom;
                    endcase
                    pb[p] = 5'($urandom_range(0, 31));
                end
                drive(p, pv[p], pop[p], pa[p], pb[p]);
            end
            bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Shares one 32-bit shift datapath (SLL/SRL/SRA, 5-bit shift amount) between two requesters, such as the ALU issue path and a secondary address/immediate-formatting path. Round-robin arbitration, a valid/ready request handshake per port, and one registered result slot with its own valid/ready handshake and a requester tag. Sits beside the execute stage. Every accepted operation returns exactly one result, in acceptance order.

## Interface
- Parameters: none. Widths are fixed: data 32 bits, shift amount 5 bits, 2 requesters.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has an operation pending.
- o_req0_ready  out  1  requester 0 operation accepted this cycle (valid && ready = handshake).
- i_req0_op  in  2  00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved.
- i_req0_a  in  32  operand to shift.
- i_req0_b  in  5  shift amount.
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b  same as the port 0 signals, for requester 1.
- o_rsp_valid  out  1  result slot holds a result.
- i_rsp_ready  in  1  consumer takes the result this cycle.
- o_rsp_id  out  1  requester that issued the held result.
- o_rsp_data  out  32  shifted result.
- o_rsp_err  out  1  held operation used the reserved op; o_rsp_data is 0.

## Operation
- State machine, two states:
  - EMPTY: the slot is empty.
  - FULL: the slot holds a result.
- Transitions:
  - EMPTY → FULL on any request handshake.
  - FULL → EMPTY on a response handshake with no new request handshake in the same cycle.
  - FULL → FULL on a response handshake and a request handshake in the same cycle (drain and refill).
  - FULL, no response handshake: hold. o_rsp_valid/id/data/err stay stable.
- can_accept = (state == EMPTY) || i_rsp_ready.
- Arbitration uses a 1-bit round-robin pointer, ptr; its reset value is 0.
  - Grant goes to port ptr if that port is valid, otherwise to the other port if it is valid.
  - o_reqN_ready = can_accept && grant == N. At most one ready is high per cycle.
  - Ready is combinationally dependent on i_reqN_valid and i_rsp_ready.
  - A port that is not valid never sees ready = 1.
  - On a handshake, ptr becomes the other port. Without a handshake, ptr holds.
  - With both ports continuously valid, grants alternate strictly.
- Datapath: the granted port's a/b/op are muxed into the shift logic and the result is written into the slot on the handshake edge. Shift results:
  - SLL: a << b, zero fill.
  - SRL: a >> b, zero fill.
  - SRA: a >> b, filled with a[31].
  - b = 0: result equals a, for all ops.
  - Reserved op 10: o_rsp_data = 0, o_rsp_err = 1. The operation is still accepted and tagged.
- Requester rules: a/b/op must stay stable while valid is high and ready is low. A requester may drop valid before a handshake; the operation is then not performed.
- Reset (any time, including with a result pending):
  - state = EMPTY, ptr = 0.
  - o_rsp_valid = 0, o_rsp_id = 0, o_rsp_data = 0, o_rsp_err = 0.
  - o_req0_ready = o_req1_ready = 0 while i_rst_n is low.
  - Any pending result is discarded.

## Timing
- Latency: a request handshake in cycle N puts the result on o_rsp_valid/id/data/err in cycle N+1.
- Throughput: 1 operation per cycle while the consumer holds i_rsp_ready high.
- Backpressure: in FULL with i_rsp_ready low, both ready outputs are 0 and nothing is accepted.
- Simultaneous response and request handshake: the old result leaves and the new result appears in the next cycle, with no bubble.
- Reset deassertion: the first request handshake is possible in the first cycle after i_rst_n rises. Port 0 wins if both ports are valid.
- No combinational path from the i_reqN_a/b/op inputs to any o_rsp_* output. All o_rsp_* outputs are registered.

## Test plan
- Reset with a result pending: load the slot, assert i_rst_n low mid-cycle with i_rsp_ready = 0 → o_rsp_valid drops asynchronously, all response outputs are 0, and ptr = 0 after release.
- Single op, port 0: SRA with a = 0x80000000, b = 4 → next cycle o_rsp_valid = 1, o_rsp_id = 0, o_rsp_data = 0xF8000000, o_rsp_err = 0.
- Edge amounts, port 1:
  - SLL 0x00000001 by 31 → 0x80000000.
  - SRL 0x80000000 by 31 → 0x00000001.
  - SRA 0x7FFFFFFF by 31 → 0x00000000.
  - Any op with b = 0 → a unchanged.
- Fairness: both ports continuously valid, i_rsp_ready = 1 → grants and o_rsp_id sequence 0,1,0,1,… with one result per cycle.
- Backpressure: fill the slot, hold i_rsp_ready = 0 for 3 cycles with both ports valid → both ready outputs are 0 and o_rsp_data is stable. Raising i_rsp_ready gives a same-cycle drain and refill.
- Reserved op: op = 10, a = 0x12345678 → o_rsp_err = 1, o_rsp_data = 0, id is correct, and ptr still toggles.
